// File: rtl/scanner_handler_array.sv
// scanner_handler_array: NUM_CH independent loader-handler channels.
// Each channel accepts level load/unload commands, runs a programmable move
// latency and reports ready/busy/done/abort/fault/op status.
// Optional feature macro: SCANNER_HANDLER_WDOG_EN adds a READY hold watchdog
// that faults a channel whose host has not released it within WDOG_CYC cycles.
module scanner_handler_array #(
    parameter int NUM_CH   = 2,
    parameter int TIMER_W  = 4,
    parameter int WDOG_CYC = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           cmd_load,
    input  logic [NUM_CH-1:0]           cmd_unload,
    input  logic [NUM_CH*TIMER_W-1:0]   lat_cfg,
    input  logic [NUM_CH-1:0]           fault_clr,
    output logic [NUM_CH-1:0]           ready,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done,
    output logic [NUM_CH-1:0]           abort,
    output logic [NUM_CH-1:0]           fault,
    output logic [NUM_CH-1:0]           op_unload
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        READY = 2'd2,
        FAULT = 2'd3
    } stateT;

    // The hold counter is 8 bits wide, so the limit must fit in it.
    if (WDOG_CYC < 1 || WDOG_CYC > 255) begin : gWdogRangeCheck
        $error("WDOG_CYC must be in the range 1..255");
    end

    stateT               state_q    [NUM_CH];
    stateT               state_d    [NUM_CH];
    logic [TIMER_W-1:0]  timer_q    [NUM_CH];
    logic [TIMER_W-1:0]  timer_d    [NUM_CH];
    logic [TIMER_W-1:0]  lat_q      [NUM_CH];
    logic [TIMER_W-1:0]  lat_d      [NUM_CH];
    logic [TIMER_W-1:0]  latField   [NUM_CH];
    logic [NUM_CH-1:0]   opUnload_q;
    logic [NUM_CH-1:0]   opUnload_d;
    logic [NUM_CH-1:0]   done_q;
    logic [NUM_CH-1:0]   done_d;
    logic [NUM_CH-1:0]   abort_q;
    logic [NUM_CH-1:0]   abort_d;
    logic [NUM_CH-1:0]   reqVec;
    logic [NUM_CH-1:0]   conflictVec;
`ifdef SCANNER_HANDLER_WDOG_EN
    localparam logic [7:0] WdogLimit = 8'(WDOG_CYC - 1);
    logic [7:0]          holdCnt_q  [NUM_CH];
    logic [7:0]          holdCnt_d  [NUM_CH];
`endif

    // A channel requests a move when exactly one command is set; both set is a conflict.
    assign reqVec      = cmd_load ^ cmd_unload;
    assign conflictVec = cmd_load & cmd_unload;

    for (genvar g = 0; g < NUM_CH; g++) begin : gLatField
        assign latField[g] = lat_cfg[g*TIMER_W +: TIMER_W];
    end

    // Per-channel next-state logic; the pulses default low and are set only on
    // the transitions that report them.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch]    = state_q[ch];
            timer_d[ch]    = timer_q[ch];
            lat_d[ch]      = lat_q[ch];
            opUnload_d[ch] = opUnload_q[ch];
            done_d[ch]     = 1'b0;
            abort_d[ch]    = 1'b0;

            unique case (state_q[ch])
                IDLE: begin
                    if (conflictVec[ch]) begin
                        state_d[ch] = FAULT;
                    end else if (reqVec[ch]) begin
                        state_d[ch]    = MOVE;
                        opUnload_d[ch] = cmd_unload[ch];
                        lat_d[ch]      = (latField[ch] == '0) ? TIMER_W'(1) : latField[ch];
                        timer_d[ch]    = TIMER_W'(1);
                    end
                end
                MOVE: begin
                    if (conflictVec[ch]) begin
                        state_d[ch] = FAULT;
                        abort_d[ch] = 1'b1;
                    end else if (!reqVec[ch] || (cmd_unload[ch] != opUnload_q[ch])) begin
                        state_d[ch] = IDLE;
                        abort_d[ch] = 1'b1;
                    end else if (timer_q[ch] == lat_q[ch]) begin
                        state_d[ch] = READY;
                        done_d[ch]  = 1'b1;
                    end else begin
                        timer_d[ch] = timer_q[ch] + TIMER_W'(1);
                    end
                end
                READY: begin
                    if (conflictVec[ch]) begin
                        state_d[ch] = FAULT;
                    end else if (!reqVec[ch] || (cmd_unload[ch] != opUnload_q[ch])) begin
                        state_d[ch] = IDLE;
`ifdef SCANNER_HANDLER_WDOG_EN
                    end else if (holdCnt_q[ch] == WdogLimit) begin
                        state_d[ch] = FAULT;
`endif
                    end
                end
                FAULT: begin
                    if (fault_clr[ch] && !cmd_load[ch] && !cmd_unload[ch]) begin
                        state_d[ch] = IDLE;
                    end
                end
                default: begin
                    state_d[ch] = IDLE;
                end
            endcase

`ifdef SCANNER_HANDLER_WDOG_EN
            holdCnt_d[ch] = ((state_q[ch] == READY) && (state_d[ch] == READY))
                            ? holdCnt_q[ch] + 8'd1 : 8'd0;
`endif
        end
    end

    // Channel registers; reset returns everything to IDLE with no pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= IDLE;
                timer_q[ch] <= '0;
                lat_q[ch]   <= '0;
`ifdef SCANNER_HANDLER_WDOG_EN
                holdCnt_q[ch] <= '0;
`endif
            end
            opUnload_q <= '0;
            done_q     <= '0;
            abort_q    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                timer_q[ch] <= timer_d[ch];
                lat_q[ch]   <= lat_d[ch];
`ifdef SCANNER_HANDLER_WDOG_EN
                holdCnt_q[ch] <= holdCnt_d[ch];
`endif
            end
            opUnload_q <= opUnload_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    // Status flags are plain decodes of the registered channel state.
    always_comb begin
        ready = '0;
        busy  = '0;
        fault = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ready[ch] = (state_q[ch] == READY);
            busy[ch]  = (state_q[ch] == MOVE);
            fault[ch] = (state_q[ch] == FAULT);
        end
    end

    assign done      = done_q;
    assign abort     = abort_q;
    assign op_unload = opUnload_q;

endmodule

// File: tb/tb_scanner_handler_array.sv
// Directed testbench for scanner_handler_array (two channels, 4-bit timers).
// Build with SCANNER_HANDLER_WDOG_EN defined to exercise the READY watchdog
// with WDOG_CYC = 10; otherwise READY is expected to hold indefinitely.
module tb_scanner_handler_array;

    logic       clk;
    logic       reset;
    logic [1:0] cmdLoad;
    logic [1:0] cmdUnload;
    logic [7:0] latCfg;
    logic [1:0] faultClr;
    logic [1:0] ready;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] abort;
    logic [1:0] fault;
    logic [1:0] opUnload;

    int total = 0;
    int bad   = 0;

`ifdef SCANNER_HANDLER_WDOG_EN
    localparam int WdogCyc = 10;
`else
    localparam int WdogCyc = 255;
`endif

    scanner_handler_array #(
        .NUM_CH   (2),
        .TIMER_W  (4),
        .WDOG_CYC (WdogCyc)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_load   (cmdLoad),
        .cmd_unload (cmdUnload),
        .lat_cfg    (latCfg),
        .fault_clr  (faultClr),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .fault      (fault),
        .op_unload  (opUnload)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] ld, input logic [1:0] ul,
                                 input logic [3:0] lat0, input logic [3:0] lat1,
                                 input logic [1:0] fclr);
        cmdLoad   = ld;
        cmdUnload = ul;
        latCfg    = {lat1, lat0};
        faultClr  = fclr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        reset = 1'b1;
        applyStimulus(2'b01, 2'b00, 4'd4, 4'd0, 2'b00);
        repeat (3) tick();
        checkOutput("rst_ready", ready, 2'b00);
        checkOutput("rst_busy", busy, 2'b00);
        checkOutput("rst_done", done, 2'b00);
        checkOutput("rst_abort", abort, 2'b00);
        checkOutput("rst_fault", fault, 2'b00);
        checkOutput("rst_op", opUnload, 2'b00);

        $display("[TB] ch0 load, latency 4");
        reset = 1'b0;
        tick();
        checkOutput("lat4_e0_busy", busy, 2'b01);
        checkOutput("lat4_e0_ready", ready, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("lat4_move_busy", busy, 2'b01);
            checkOutput("lat4_move_ready", ready, 2'b00);
        end
        tick();
        checkOutput("lat4_e4_ready", ready, 2'b01);
        checkOutput("lat4_e4_done", done, 2'b01);
        checkOutput("lat4_e4_busy", busy, 2'b00);
        checkOutput("lat4_e4_op", opUnload, 2'b00);
        tick();
        checkOutput("lat4_e5_done", done, 2'b00);
        checkOutput("lat4_e5_ready", ready, 2'b01);
        applyStimulus(2'b00, 2'b00, 4'd4, 4'd0, 2'b00);
        tick();
        checkOutput("release_ready", ready, 2'b00);
        checkOutput("release_abort", abort, 2'b00);

        $display("[TB] concurrent ch0 load lat 3, ch1 unload lat 0");
        applyStimulus(2'b01, 2'b10, 4'd3, 4'd0, 2'b00);
        tick();
        checkOutput("conc_e0_busy", busy, 2'b11);
        tick();
        checkOutput("conc_e1_ready", ready, 2'b10);
        checkOutput("conc_e1_done", done, 2'b10);
        checkOutput("conc_e1_op", opUnload, 2'b10);
        checkOutput("conc_e1_busy", busy, 2'b01);
        tick();
        checkOutput("conc_e2_busy", busy, 2'b01);
        checkOutput("conc_e2_done", done, 2'b00);
        tick();
        checkOutput("conc_e3_ready", ready, 2'b11);
        checkOutput("conc_e3_done", done, 2'b01);
        applyStimulus(2'b00, 2'b00, 4'd3, 4'd0, 2'b00);
        tick();
        checkOutput("conc_rel_ready", ready, 2'b00);

        $display("[TB] ch0 abort after two MOVE cycles, cfg change ignored");
        applyStimulus(2'b01, 2'b00, 4'd6, 4'd0, 2'b00);
        tick();
        checkOutput("abt_e0_busy", busy, 2'b01);
        applyStimulus(2'b01, 2'b00, 4'd1, 4'd0, 2'b00);
        tick();
        checkOutput("abt_e1_busy", busy, 2'b01);
        checkOutput("abt_e1_ready", ready, 2'b00);
        applyStimulus(2'b00, 2'b00, 4'd1, 4'd0, 2'b00);
        tick();
        checkOutput("abt_e2_abort", abort, 2'b01);
        checkOutput("abt_e2_busy", busy, 2'b00);
        checkOutput("abt_e2_done", done, 2'b00);
        tick();
        checkOutput("abt_e3_abort", abort, 2'b00);
        checkOutput("abt_e3_done", done, 2'b00);

        $display("[TB] ch0 op swap during MOVE");
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 2'b00);
        tick();
        checkOutput("swap_e0_busy", busy, 2'b01);
        checkOutput("swap_e0_op", opUnload, 2'b10);
        applyStimulus(2'b00, 2'b01, 4'd5, 4'd0, 2'b00);
        tick();
        checkOutput("swap_e1_abort", abort, 2'b01);
        checkOutput("swap_e1_busy", busy, 2'b00);
        tick();
        checkOutput("swap_e2_busy", busy, 2'b01);
        checkOutput("swap_e2_op", opUnload, 2'b11);
        checkOutput("swap_e2_abort", abort, 2'b00);
        applyStimulus(2'b00, 2'b00, 4'd5, 4'd0, 2'b00);
        tick();
        checkOutput("swap_rel_abort", abort, 2'b01);
        tick();
        checkOutput("swap_rel2_abort", abort, 2'b00);

        $display("[TB] ch0 conflict from IDLE");
        applyStimulus(2'b01, 2'b01, 4'd5, 4'd0, 2'b00);
        tick();
        checkOutput("idlecf_fault", fault, 2'b01);
        checkOutput("idlecf_abort", abort, 2'b00);
        applyStimulus(2'b00, 2'b00, 4'd5, 4'd0, 2'b01);
        tick();
        checkOutput("idlecf_clr", fault, 2'b00);

        $display("[TB] ch1 conflict in MOVE, clear handshake");
        applyStimulus(2'b00, 2'b10, 4'd0, 4'd6, 2'b00);
        tick();
        checkOutput("cf_e0_busy", busy, 2'b10);
        applyStimulus(2'b10, 2'b10, 4'd0, 4'd6, 2'b00);
        tick();
        checkOutput("cf_e1_fault", fault, 2'b10);
        checkOutput("cf_e1_abort", abort, 2'b10);
        checkOutput("cf_e1_busy", busy, 2'b00);
        applyStimulus(2'b10, 2'b10, 4'd0, 4'd6, 2'b10);
        tick();
        checkOutput("cf_clr_held_fault", fault, 2'b10);
        checkOutput("cf_clr_held_abort", abort, 2'b00);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd6, 2'b00);
        tick();
        checkOutput("cf_drop_fault", fault, 2'b10);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd6, 2'b10);
        tick();
        checkOutput("cf_clr_fault", fault, 2'b00);
        tick();
        checkOutput("cf_idle_clr_fault", fault, 2'b00);
        checkOutput("cf_idle_clr_ready", ready, 2'b00);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd6, 2'b00);

        $display("[TB] ch0 hold in READY");
        applyStimulus(2'b01, 2'b00, 4'd1, 4'd0, 2'b00);
        tick();
        checkOutput("hold_e0_busy", busy, 2'b01);
        tick();
        checkOutput("hold_e1_ready", ready, 2'b01);
        checkOutput("hold_e1_done", done, 2'b01);
`ifdef SCANNER_HANDLER_WDOG_EN
        for (int i = 1; i < WdogCyc; i++) begin
            tick();
            checkOutput("wdog_hold_ready", ready, 2'b01);
        end
        tick();
        checkOutput("wdog_fault", fault, 2'b01);
        checkOutput("wdog_ready", ready, 2'b00);
`else
        for (int i = 0; i < 60; i++) begin
            tick();
            checkOutput("hold_ready", ready, 2'b01);
        end
        checkOutput("hold_fault", fault, 2'b00);
`endif

        $display("[TB] reset during MOVE");
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 4'd3, 4'd0, 2'b00);
        tick();
        reset = 1'b0;
        applyStimulus(2'b01, 2'b00, 4'd3, 4'd0, 2'b00);
        tick();
        checkOutput("midrst_e0_busy", busy, 2'b01);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_busy", busy, 2'b00);
        checkOutput("midrst_abort", abort, 2'b00);
        checkOutput("midrst_done", done, 2'b00);
        checkOutput("midrst_ready", ready, 2'b00);
        reset = 1'b0;
        tick();
        checkOutput("midrst_restart_busy", busy, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
